uart_rx_os: RTL and testbench



---
 rtl/uart_rx_os.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_os.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-FF synchroniser, 3-sample majority voting, false-start
// rejection, parity/framing/break detection and a valid/ready output handshake.
module uart_rx_os #(
    parameter int unsigned DIV        = 4,
    parameter int unsigned OS         = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 rx_clk,
    input  logic                 reset_n,
    input  logic                 rx_serial,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PW = $clog2(OS);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } state_e;

    state_e               state;
    logic                 s_meta, s, s_prev;
    logic [TW-1:0]        tick_cnt;
    logic [PW-1:0]        ph;
    logic [BW-1:0]        bit_cnt;
    logic                 stop_cnt;
    logic                 smp1, smp2;
    logic [DATA_BITS-1:0] shreg;
    logic                 pe, fe, par_bit;
    logic                 tick, bit_end, at_s1, at_s2, at_maj, maj, fe_now, last_stop;

    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            s_meta <= 1'b1;
            s      <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            s_meta <= rx_serial;
            s      <= s_meta;
            s_prev <= s;
        end
    end

    // Sample points are the ticks that move ph onto OS/2-1, OS/2 and OS/2+1; the vote is
    // resolved on the third one using the live synchronised value.
    always_comb begin
        tick      = (tick_cnt == TW'(DIV - 1));
        bit_end   = tick && (ph == PW'(OS - 1));
        at_s1     = tick && (ph == PW'(OS / 2 - 2));
        at_s2     = tick && (ph == PW'(OS / 2 - 1));
        at_maj    = tick && (ph == PW'(OS / 2));
        maj       = (smp1 & smp2) | (smp1 & s) | (smp2 & s);
        fe_now    = fe | ~maj;
        last_stop = (stop_cnt == 1'(STOP_BITS - 1));
    end

    always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StIdle;
            tick_cnt   <= '0;
            ph         <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            smp1       <= 1'b0;
            smp2       <= 1'b0;
            shreg      <= '0;
            pe         <= 1'b0;
            fe         <= 1'b0;
            par_bit    <= 1'b0;
            rx_busy    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            break_det <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;

            if (state == StIdle) begin
                tick_cnt <= '0;
                ph       <= '0;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                if (tick) ph <= (ph == PW'(OS - 1)) ? '0 : ph + 1'b1;
                if (at_s1) smp1 <= s;
                if (at_s2) smp2 <= s;
            end

            case (state)
                StIdle: begin
                    if (s_prev && !s) begin
                        state    <= StStart;
                        rx_busy  <= 1'b1;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        pe       <= 1'b0;
                        fe       <= 1'b0;
                        par_bit  <= 1'b0;
                    end
                end
                StStart: begin
                    if (at_maj && maj) begin
                        state   <= StIdle;
                        rx_busy <= 1'b0;
                    end else if (bit_end) begin
                        state <= StData;
                    end
                end
                StData: begin
                    if (at_maj) begin
                        shreg   <= {maj, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (bit_end && bit_cnt == BW'(DATA_BITS)) begin
                        state <= (PARITY_EN != 0) ? StParity : StStop;
                    end
                end
                StParity: begin
                    if (at_maj) begin
                        par_bit <= maj;
                        pe      <= maj != (^shreg ^ 1'(PARITY_ODD));
                    end
                    if (bit_end) state <= StStop;
                end
                StStop: begin
                    if (at_maj) begin
                        fe <= fe_now;
                        if (last_stop) begin
                            // Complete at the vote point; the rest of the stop bit is not awaited.
                            state      <= fe_now ? StWaitIdle : StIdle;
                            rx_busy    <= 1'b0;
                            rx_data    <= shreg;
                            parity_err <= pe;
                            frame_err  <= fe_now;
                            rx_valid   <= 1'b1;
                            rx_done    <= 1'b1;
                            overrun    <= rx_valid && !rx_ready;
                            break_det  <= (shreg == '0) && !par_bit && fe_now;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                StWaitIdle: begin
                    if (s) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed + randomised bench for uart_rx_os: a default-parameter instance and a
// 7-bit / odd-parity / 2-stop instance, checked against a frame-level reference model.
module tb_uart_rx_os;

    localparam int unsigned BIT = 64;
    localparam int unsigned GAP = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       ser1, rdy1, busy1, valid1, done1, pe1, fe1, brk1, ovr1;
    logic [7:0] data1;
    logic       ser2, rdy2, busy2, valid2, done2, pe2, fe2, brk2, ovr2;
    logic [6:0] data2;

    uart_rx_os dut1 (
        .rx_clk    (clk),
        .reset_n   (reset_n),
        .rx_serial (ser1),
        .rx_ready  (rdy1),
        .rx_busy   (busy1),
        .rx_data   (data1),
        .rx_valid  (valid1),
        .rx_done   (done1),
        .parity_err(pe1),
        .frame_err (fe1),
        .break_det (brk1),
        .overrun   (ovr1)
    );

    uart_rx_os #(
        .DIV       (4),
        .OS        (16),
        .DATA_BITS (7),
        .PARITY_EN (1),
        .PARITY_ODD(1),
        .STOP_BITS (2)
    ) dut2 (
        .rx_clk    (clk),
        .reset_n   (reset_n),
        .rx_serial (ser2),
        .rx_ready  (rdy2),
        .rx_busy   (busy2),
        .rx_data   (data2),
        .rx_valid  (valid2),
        .rx_done   (done2),
        .parity_err(pe2),
        .frame_err (fe2),
        .break_det (brk2),
        .overrun   (ovr2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_start = 0;

    // Event monitors: pulse counts and the outputs captured on each rx_done.
    int done_n1 = 0, brk_n1 = 0, ovr_n1 = 0, busy_n1 = 0, done_cyc1 = 0;
    int done_n2 = 0, brk_n2 = 0, ovr_n2 = 0, busy_n2 = 0, done_cyc2 = 0;
    logic [7:0] cap_data1 = '0;
    logic [6:0] cap_data2 = '0;
    logic cap_pe1 = 0, cap_fe1 = 0, cap_v1 = 0, cap_pe2 = 0, cap_fe2 = 0, cap_v2 = 0;
    int b_done1, b_brk1, b_ovr1, b_busy1, b_done2, b_brk2, b_ovr2;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done1) begin
            done_n1   <= done_n1 + 1;
            done_cyc1 <= cyc;
            cap_data1 <= data1;
            cap_pe1   <= pe1;
            cap_fe1   <= fe1;
            cap_v1    <= valid1;
        end
        if (done2) begin
            done_n2   <= done_n2 + 1;
            done_cyc2 <= cyc;
            cap_data2 <= data2;
            cap_pe2   <= pe2;
            cap_fe2   <= fe2;
            cap_v2    <= valid2;
        end
        if (brk1) brk_n1 <= brk_n1 + 1;
        if (ovr1) ovr_n1 <= ovr_n1 + 1;
        if (busy1) busy_n1 <= busy_n1 + 1;
        if (brk2) brk_n2 <= brk_n2 + 1;
        if (ovr2) ovr_n2 <= ovr_n2 + 1;
        if (busy2) busy_n2 <= busy_n2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_done1 = done_n1; b_brk1 = brk_n1; b_ovr1 = ovr_n1; b_busy1 = busy_n1;
        b_done2 = done_n2; b_brk2 = brk_n2; b_ovr2 = ovr_n2;
    endtask

    // Reference model: plain frame arithmetic.
    function automatic logic par_of(input logic [8:0] d, input int unsigned nbits, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < int'(nbits); i++) p = p ^ d[i];
        return p;
    endfunction

    function automatic logic fe_of(input logic [1:0] st, input int unsigned nstop);
        return (nstop == 1) ? !st[0] : !(st[0] && st[1]);
    endfunction

    task automatic set_line(input int unsigned which, input logic v);
        if (which == 0) ser1 = v;
        else ser2 = v;
    endtask

    task automatic drive_bit(input int unsigned which, input logic v);
        set_line(which, v);
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send(input int unsigned which, input logic [8:0] d, input int unsigned nbits,
                        input logic pb, input logic [1:0] st, input int unsigned nstop,
                        input int unsigned tail_low);
        t_start = cyc;
        drive_bit(which, 1'b0);
        for (int i = 0; i < int'(nbits); i++) drive_bit(which, d[i]);
        drive_bit(which, pb);
        for (int i = 0; i < int'(nstop); i++) drive_bit(which, st[i]);
        if (tail_low != 0) begin
            set_line(which, 1'b0);
            repeat (tail_low) @(negedge clk);
        end
        set_line(which, 1'b1);
        repeat (GAP) @(negedge clk);
    endtask

    task automatic expect_frame(input string tag, input int unsigned which, input logic [8:0] d,
                                input int unsigned nbits, input logic pb, input logic [1:0] st,
                                input int unsigned nstop, input logic exp_ovr);
        logic       odd, e_pe, e_fe, e_brk;
        int         dn, bn, on, lat, lo;
        logic [8:0] cd;
        logic       cpe, cfe, cv, bsy;
        odd   = (which == 0) ? 1'b0 : 1'b1;
        e_pe  = (pb != par_of(d, nbits, odd));
        e_fe  = fe_of(st, nstop);
        e_brk = (d == 9'd0) && !pb && e_fe;
        if (which == 0) begin
            dn = done_n1 - b_done1; bn = brk_n1 - b_brk1; on = ovr_n1 - b_ovr1;
            lat = done_cyc1 - t_start; cd = {1'b0, cap_data1};
            cpe = cap_pe1; cfe = cap_fe1; cv = cap_v1; bsy = busy1;
        end else begin
            dn = done_n2 - b_done2; bn = brk_n2 - b_brk2; on = ovr_n2 - b_ovr2;
            lat = done_cyc2 - t_start; cd = {2'b0, cap_data2};
            cpe = cap_pe2; cfe = cap_fe2; cv = cap_v2; bsy = busy2;
        end
        // Pin edge to completion: 2..3 detection cycles plus the frame formula, +/-1.
        lo = int'((nbits + 1 + nstop) * BIT + (16 / 2 + 1) * 4) + 1;
        check({tag, ":done_pulses"}, 32'(dn), 32'd1);
        check({tag, ":data"}, 32'(cd), 32'(d));
        check({tag, ":parity_err"}, 32'(cpe), 32'(e_pe));
        check({tag, ":frame_err"}, 32'(cfe), 32'(e_fe));
        check({tag, ":valid_at_done"}, 32'(cv), 32'd1);
        check({tag, ":break_pulses"}, 32'(bn), 32'(e_brk));
        check({tag, ":overrun_pulses"}, 32'(on), 32'(exp_ovr));
        check({tag, ":latency_ok"}, 32'(lat >= lo && lat <= lo + 3), 32'd1);
        check({tag, ":busy_after"}, 32'(bsy), 32'd0);
    endtask

    logic [8:0] d;
    logic       pb;
    logic [1:0] st;

    initial begin
        ser1 = 1'b1; ser2 = 1'b1; rdy1 = 1'b0; rdy2 = 1'b1; reset_n = 1'b0;
        repeat (4) @(negedge clk);
        check("reset:data1", 32'(data1), 32'd0);
        check("reset:flags1", 32'({busy1, valid1, done1, pe1, fe1, brk1, ovr1}), 32'd0);
        check("reset:data2", 32'(data2), 32'd0);
        check("reset:flags2", 32'({busy2, valid2, done2, pe2, fe2, brk2, ovr2}), 32'd0);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);

        // Good frame, held un-acknowledged, then accepted.
        snap(); send(0, 9'h3C, 8, 1'b0, 2'b11, 1, 0);
        expect_frame("t1", 0, 9'h3C, 8, 1'b0, 2'b11, 1, 1'b0);
        check("t1:valid_held", 32'(valid1), 32'd1);
        rdy1 = 1'b1;
        @(negedge clk);
        check("t1:valid_cleared", 32'(valid1), 32'd0);

        // Wrong parity bit.
        snap(); send(0, 9'h9D, 8, 1'b0, 2'b11, 1, 0);
        expect_frame("t2", 0, 9'h9D, 8, 1'b0, 2'b11, 1, 1'b0);

        // Low stop bit.
        snap(); send(0, 9'hF0, 8, 1'b0, 2'b00, 1, 0);
        expect_frame("t3", 0, 9'hF0, 8, 1'b0, 2'b00, 1, 1'b0);

        // Short glitch: false start.
        snap();
        set_line(0, 1'b0);
        repeat (20) @(negedge clk);
        set_line(0, 1'b1);
        repeat (100) @(negedge clk);
        check("t4:busy_seen", 32'(busy_n1 > b_busy1), 32'd1);
        check("t4:busy_low", 32'(busy1), 32'd0);
        check("t4:no_done", 32'(done_n1 - b_done1), 32'd0);
        check("t4:no_pulses", 32'((brk_n1 - b_brk1) + (ovr_n1 - b_ovr1)), 32'd0);

        // Break: all-zero frame then line held low; no retrigger.
        snap(); send(0, 9'h00, 8, 1'b0, 2'b00, 1, 3 * BIT);
        expect_frame("t5", 0, 9'h00, 8, 1'b0, 2'b00, 1, 1'b0);

        // Overrun with consumer stalled.
        rdy1 = 1'b0;
        snap(); send(0, 9'h11, 8, par_of(9'h11, 8, 1'b0), 2'b11, 1, 0);
        expect_frame("t6a", 0, 9'h11, 8, par_of(9'h11, 8, 1'b0), 2'b11, 1, 1'b0);
        snap(); send(0, 9'h22, 8, par_of(9'h22, 8, 1'b0), 2'b11, 1, 0);
        expect_frame("t6b", 0, 9'h22, 8, par_of(9'h22, 8, 1'b0), 2'b11, 1, 1'b1);
        rdy1 = 1'b1;
        @(negedge clk);
        check("t6:valid_cleared", 32'(valid1), 32'd0);

        // Reset mid-data, then a clean frame.
        rdy1 = 1'b0;
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        repeat (BIT / 2) @(negedge clk);
        check("t7:busy_pre", 32'(busy1), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t7:data_rst", 32'(data1), 32'd0);
        check("t7:flags_rst", 32'({busy1, valid1, done1, pe1, fe1, brk1, ovr1}), 32'd0);
        @(negedge clk);
        set_line(0, 1'b1);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        rdy1 = 1'b1;
        repeat (8) @(negedge clk);
        snap(); send(0, 9'hA5, 8, 1'b0, 2'b11, 1, 0);
        expect_frame("t7", 0, 9'hA5, 8, 1'b0, 2'b11, 1, 1'b0);

        // Randomised frames on the default instance.
        for (int i = 0; i < 12; i++) begin
            d  = (i % 4 == 0) ? 9'd0 : 9'($urandom_range(0, 255));
            pb = par_of(d, 8, 1'b0) ^ ($urandom_range(0, 3) == 0);
            st = {1'b1, 1'($urandom_range(0, 3) != 0)};
            snap(); send(0, d, 8, pb, st, 1, 0);
            expect_frame($sformatf("rnd1_%0d", i), 0, d, 8, pb, st, 1, 1'b0);
        end

        // 7 data bits, odd parity, two stop bits.
        snap(); send(1, 9'h55, 7, 1'b1, 2'b11, 2, 0);
        expect_frame("t8", 1, 9'h55, 7, 1'b1, 2'b11, 2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            d  = (i % 4 == 0) ? 9'd0 : 9'($urandom_range(0, 127));
            pb = par_of(d, 7, 1'b1) ^ ($urandom_range(0, 3) == 0);
            st = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
            snap(); send(1, d, 7, pb, st, 2, 0);
            expect_frame($sformatf("rnd2_%0d", i), 1, d, 7, pb, st, 2, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
